// File: rtl/kf_axi_pkg.sv
// Shared AXI read-arbiter types: FSM state encoding, AR capture record and common AXI field constants.
package kf_axi_pkg;

  localparam int AXI_ADDR_MAX_W = 64;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_64B   = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  // Address is stored at the widest supported width; the top uses the low ADDR_W bits.
  typedef struct packed {
    logic [AXI_ADDR_MAX_W-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
  } axi_ar_t;

endpackage

// File: rtl/kf_rr_pick.sv
// Combinational round-robin picker: first active request searching upward from last+1, wrapping modulo NUM_REQ.
module kf_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         idx,
  output logic               vld
);

  logic [3:0] req_pad_s;
  logic [3:0] gnt_pad_s;
  logic [1:0] pos_s;

  assign req_pad_s = 4'(req);

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    idx   = 2'd0;
    pos_s = 2'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos_s = 2'((int'(last) + k) % NUM_REQ);
      idx   = req_pad_s[pos_s] ? pos_s : idx;
    end
  end

  assign vld       = |req;
  assign gnt_pad_s = 4'b0001 << idx;
  assign gnt       = vld ? gnt_pad_s[NUM_REQ-1:0] : '0;

endmodule

// File: rtl/kf_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master (AR+R) among NUM_REQ clients, one burst at a time.
// Optional R-channel stall timeout enabled by defining KF_RD_ARB_TIMEOUT_EN.
module kf_axi_rd_arbiter
  import kf_axi_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 512,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ*ADDR_W-1:0] s_araddr,
  input  logic [NUM_REQ*8-1:0]    s_arlen,
  input  logic [NUM_REQ*3-1:0]    s_arsize,
  input  logic [NUM_REQ*2-1:0]    s_arburst,
  input  logic [NUM_REQ-1:0]      s_arvalid,
  output logic [NUM_REQ-1:0]      s_arready,
  output logic [DATA_W-1:0]       s_rdata,
  output logic [NUM_REQ-1:0]      s_rvalid,
  input  logic [NUM_REQ-1:0]      s_rready,
  output logic [ADDR_W-1:0]       m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic                    busy,
  output logic [1:0]              grant_id,
  output logic                    timeout_err
);

  arb_state_t state_q, state_d;
  axi_ar_t    ar_q, ar_d;
  logic [7:0] beat_q, beat_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;

  logic [NUM_REQ-1:0] pick_gnt_s;
  logic [1:0]         pick_idx_s;
  logic               pick_vld_s;
  logic [NUM_REQ-1:0] arready_s;
  logic [3:0]         rready_pad_s;
  logic [3:0]         rvalid_pad_s;
  logic               m_rready_s;
  logic               hs_s;
  logic               unused_addr_s;

  logic [ADDR_W-1:0] req_addr_s  [4];
  logic [7:0]        req_len_s   [4];
  logic [2:0]        req_size_s  [4];
  logic [1:0]        req_burst_s [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_req
    if (gi < NUM_REQ) begin : g_on
      assign req_addr_s[gi]  = s_araddr[gi*ADDR_W +: ADDR_W];
      assign req_len_s[gi]   = s_arlen[gi*8 +: 8];
      assign req_size_s[gi]  = s_arsize[gi*3 +: 3];
      assign req_burst_s[gi] = s_arburst[gi*2 +: 2];
    end else begin : g_off
      assign req_addr_s[gi]  = '0;
      assign req_len_s[gi]   = 8'd0;
      assign req_size_s[gi]  = 3'd0;
      assign req_burst_s[gi] = 2'd0;
    end
  end

  assign rready_pad_s = 4'(s_rready);

  kf_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req  (s_arvalid),
    .last (last_q),
    .gnt  (pick_gnt_s),
    .idx  (pick_idx_s),
    .vld  (pick_vld_s)
  );

`ifdef KF_RD_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC) + 1;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout_q, timeout_d;
`endif

  // Next-state, capture and R routing; the stall counter is zero outside DATA so it restarts on every entry.
  always_comb begin
    state_d      = state_q;
    ar_d         = ar_q;
    beat_d       = beat_q;
    grant_d      = grant_q;
    last_d       = last_q;
    arready_s    = '0;
    rvalid_pad_s = 4'b0000;
    m_rready_s   = 1'b0;
    hs_s         = 1'b0;
`ifdef KF_RD_ARB_TIMEOUT_EN
    stall_d      = '0;
    timeout_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld_s) begin
          arready_s  = pick_gnt_s;
          ar_d.addr  = AXI_ADDR_MAX_W'(req_addr_s[pick_idx_s]);
          ar_d.len   = req_len_s[pick_idx_s];
          ar_d.size  = req_size_s[pick_idx_s];
          ar_d.burst = req_burst_s[pick_idx_s];
          grant_d    = pick_idx_s;
          last_d     = pick_idx_s;
          beat_d     = 8'd0;
          state_d    = ADDR;
        end else begin
          state_d    = IDLE;
        end
      end
      ADDR: begin
        if (m_arready) begin
          state_d = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        m_rready_s              = rready_pad_s[grant_q];
        rvalid_pad_s[grant_q]   = m_rvalid;
        hs_s                    = m_rvalid & m_rready_s;
        if (hs_s) begin
          beat_d = beat_q + 8'd1;
          if (beat_q == ar_q.len) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end else begin
`ifdef KF_RD_ARB_TIMEOUT_EN
          if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end else begin
            stall_d   = stall_q + STALL_W'(1);
          end
`else
          state_d = DATA;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter state and captured AR request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ar_q    <= '0;
      beat_q  <= 8'd0;
      grant_q <= 2'd0;
      last_q  <= 2'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      beat_q  <= beat_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef KF_RD_ARB_TIMEOUT_EN
  // R-channel stall counter and one-cycle timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign s_arready = arready_s;
  assign s_rvalid  = rvalid_pad_s[NUM_REQ-1:0];
  assign m_rready  = m_rready_s;
  // Data is gated to DATA so nothing leaks toward clients in reset or between bursts.
  assign s_rdata   = (state_q == DATA) ? m_rdata : '0;
  assign m_araddr  = ar_q.addr[ADDR_W-1:0];
  assign m_arlen   = ar_q.len;
  assign m_arsize  = ar_q.size;
  assign m_arburst = ar_q.burst;
  assign m_arvalid = (state_q == ADDR);
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;

  assign unused_addr_s = ^ar_q.addr;

endmodule

// File: tb/tb_kf_axi_rd_arbiter.sv
// Directed bench for kf_axi_rd_arbiter: round-robin vector table plus multi-cycle burst, stall, reset and timeout sequences.
module tb_kf_axi_rd_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR*AW-1:0] s_araddr;
  logic [NR*8-1:0] s_arlen;
  logic [NR*3-1:0] s_arsize;
  logic [NR*2-1:0] s_arburst;
  logic [NR-1:0]   s_arvalid;
  logic [NR-1:0]   s_arready;
  logic [DW-1:0]   s_rdata;
  logic [NR-1:0]   s_rvalid;
  logic [NR-1:0]   s_rready;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic            m_arvalid;
  logic            m_arready;
  logic [DW-1:0]   m_rdata;
  logic            m_rvalid;
  logic            m_rready;
  logic            busy;
  logic [1:0]      grant_id;
  logic            timeout_err;

  logic [9:0]      ctl_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  kf_axi_rd_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  assign ctl_s = {s_arready, m_arvalid, busy, grant_id, s_rvalid, m_rready, timeout_err};

  typedef struct {
    logic [1:0] arvalid;
    logic       m_arready;
    logic       m_rvalid;
    logic [1:0] rready;
    logic [1:0] e_arready;
    logic       e_arvalid;
    logic       e_busy;
    logic [1:0] e_grant;
    logic [1:0] e_rvalid;
    logic       e_rready;
    logic       e_data;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [AW-1:0] a, input logic [7:0] len);
    s_araddr[r*AW +: AW] = a;
    s_arlen[r*8 +: 8]    = len;
    s_arsize[r*3 +: 3]   = kf_axi_pkg::AXI_SIZE_64B;
    s_arburst[r*2 +: 2]  = kf_axi_pkg::AXI_BURST_INCR;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  hs;
    int  k;
    int  n;
    logic done;
    logic [63:0] exp_d;

    // Two requesters valid back-to-back, len-0 bursts; grants alternate starting with 0.
    tbl[0]  = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b01, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'd0, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 2'd0, 2'b01, 1'b1, 1'b1};
    tbl[3]  = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b10, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'd1, 2'b00, 1'b0, 1'b0};
    tbl[5]  = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 2'd1, 2'b10, 1'b1, 1'b1};
    tbl[6]  = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b01, 1'b0, 1'b0, 2'd1, 2'b00, 1'b0, 1'b0};
    tbl[7]  = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'd0, 2'b00, 1'b0, 1'b0};
    tbl[8]  = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 2'd0, 2'b01, 1'b1, 1'b1};
    tbl[9]  = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b10, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0};
    tbl[10] = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'd1, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 2'd1, 2'b10, 1'b1, 1'b1};

    s_araddr  = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    s_arvalid = '0;
    s_rready  = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = 64'hA5A5_0000_1111_2222;

    // Reset state
    tick();
    tick();
    chk("reset ctl", 64'(ctl_s), 64'd0);
    chk("reset ar", 64'({m_araddr, m_arlen, m_arsize, m_arburst}), 64'd0);
    chk("reset rdata", 64'(s_rdata), 64'd0);
    tick();
    rst_n = 1'b1;
    set_req(0, 32'h0010_0000, 8'd0);
    set_req(1, 32'h0020_0000, 8'd0);

    // Table-driven round-robin
    for (int i = 0; i < 12; i++) begin
      s_arvalid = tbl[i].arvalid;
      m_arready = tbl[i].m_arready;
      m_rvalid  = tbl[i].m_rvalid;
      s_rready  = tbl[i].rready;
      m_rdata   = {32'hC0DE_0000, 32'(i)};
      #1;
      chk($sformatf("rr row %0d ctl", i), 64'(ctl_s),
          64'({tbl[i].e_arready, tbl[i].e_arvalid, tbl[i].e_busy, tbl[i].e_grant,
               tbl[i].e_rvalid, tbl[i].e_rready, 1'b0}));
      exp_d = tbl[i].e_data ? m_rdata : 64'd0;
      chk($sformatf("rr row %0d rdata", i), 64'(s_rdata), exp_d);
      tick();
    end
    s_arvalid = 2'b00;
    m_rvalid  = 1'b0;
    s_rready  = 2'b00;

    // Single 4-beat burst from requester 0
    set_req(0, 32'h0030_0000, 8'd3);
    s_arvalid = 2'b01;
    m_arready = 1'b1;
    #1;
    chk("t1 arready", 64'(s_arready), 64'h1);
    tick();
    s_arvalid = 2'b00;
    #1;
    chk("t1 ar fields", 64'({m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst}),
        64'({1'b1, 32'h0030_0000, 8'd3, 3'b110, 2'b01}));
    tick();
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1;
      s_rready = 2'b01;
      m_rdata  = 64'hBEEF_0000_0000_0000 | 64'(b);
      #1;
      chk($sformatf("t1 beat %0d ctl", b), 64'(ctl_s), 64'({2'b00, 1'b0, 1'b1, 2'd0, 2'b01, 1'b1, 1'b0}));
      chk($sformatf("t1 beat %0d rdata", b), 64'(s_rdata), 64'hBEEF_0000_0000_0000 | 64'(b));
      tick();
    end
    m_rvalid = 1'b0;
    s_rready = 2'b00;
    #1;
    chk("t1 busy after last beat", 64'(busy), 64'd0);
    tick();

    // Requester 1 granted, master AR stalled for 5 cycles
    set_req(1, 32'h1234_5600, 8'd0);
    set_req(0, 32'h0055_0000, 8'd7);
    s_arvalid = 2'b11;
    m_arready = 1'b0;
    #1;
    chk("t3 arready", 64'(s_arready), 64'h2);
    tick();
    s_arvalid = 2'b01;
    for (int c = 0; c < 6; c++) begin
      m_arready = (c == 5);
      #1;
      chk($sformatf("t3 addr hold %0d", c), 64'({m_arvalid, m_araddr, s_arready}),
          64'({1'b1, 32'h1234_5600, 2'b00}));
      tick();
    end
    m_rvalid = 1'b1;
    s_rready = 2'b11;
    m_rdata  = 64'h0000_0000_DEAD_0001;
    #1;
    chk("t3 data ctl", 64'(ctl_s), 64'({2'b00, 1'b0, 1'b1, 2'd1, 2'b10, 1'b1, 1'b0}));
    tick();
    #1;
    chk("t3 idle with rvalid", 64'(ctl_s), 64'({2'b01, 1'b0, 1'b0, 2'd1, 2'b00, 1'b0, 1'b0}));
    tick();
    s_arvalid = 2'b00;
    m_arready = 1'b1;
    #1;
    chk("t4 addr with rvalid", 64'({m_arvalid, m_arlen, m_rready, s_rvalid}),
        64'({1'b1, 8'd7, 1'b0, 2'b00}));
    tick();
    m_arready = 1'b0;

    // Owner's s_rready toggling during an 8-beat burst
    hs   = 0;
    k    = 0;
    done = 1'b0;
    while (!done && k < 40) begin
      s_rready = {1'b1, (k % 2 == 0)};
      m_rvalid = 1'b1;
      #1;
      chk($sformatf("t4 cycle %0d", k), 64'({m_rready, s_rvalid, busy}),
          64'({s_rready[0], 2'b01, 1'b1}));
      if (s_rready[0]) hs++;
      tick();
      if (hs == 8) done = 1'b1;
      k++;
    end
    chk("t4 cycles", 64'(k), 64'd15);
    m_rvalid = 1'b0;
    s_rready = 2'b00;
    #1;
    chk("t4 busy after 8 beats", 64'(busy), 64'd0);
    tick();

    // Async reset in the middle of a burst
    set_req(0, 32'h0066_0000, 8'd7);
    s_arvalid = 2'b01;
    tick();
    s_arvalid = 2'b00;
    m_arready = 1'b1;
    tick();
    m_rvalid = 1'b1;
    s_rready = 2'b01;
    tick();
    tick();
    s_rready = 2'b11;
    rst_n    = 1'b0;
    #1;
    chk("t5 reset ctl", 64'(ctl_s), 64'd0);
    chk("t5 reset ar", 64'({m_araddr, m_arlen, m_arsize, m_arburst}), 64'd0);
    chk("t5 reset rdata", 64'(s_rdata), 64'd0);
    tick();
    rst_n = 1'b1;
    set_req(0, 32'h0077_0000, 8'd0);
    set_req(1, 32'h0088_0000, 8'd0);
    s_arvalid = 2'b11;
    m_rvalid  = 1'b0;
    s_rready  = 2'b00;
    #1;
    chk("t5 first winner", 64'({s_arready, grant_id, busy}), 64'({2'b01, 2'd0, 1'b0}));
    tick();
    s_arvalid = 2'b00;
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    s_rready  = 2'b01;
    tick();
    m_rvalid  = 1'b0;
    s_rready  = 2'b00;

    // R-channel stall in DATA
    set_req(0, 32'h0099_0000, 8'd0);
    s_arvalid = 2'b01;
    tick();
    s_arvalid = 2'b00;
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    s_rready  = 2'b01;
`ifdef KF_RD_ARB_TIMEOUT_EN
    n    = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (timeout_err) done = 1'b1;
    end
    chk("t6 timeout cycle", 64'(n), 64'd16);
    chk("t6 busy at timeout", 64'({busy, timeout_err}), 64'({1'b0, 1'b1}));
    tick();
    chk("t6 pulse width", 64'(timeout_err), 64'd0);
`else
    for (n = 0; n < 40; n++) begin
      tick();
      chk($sformatf("t6 stall %0d", n), 64'({busy, timeout_err}), 64'({1'b1, 1'b0}));
    end
    m_rvalid = 1'b1;
    tick();
    m_rvalid = 1'b0;
    #1;
    chk("t6 flush", 64'(busy), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kf_axi_rd_arbiter.md
Name: kf_axi_rd_arbiter

Overview:
Shares one AXI4 read master port (AR + R channels) between NUM_REQ read clients, e.g. the initial-parameter reader (X_00/P_00) and the Zk prefetch reader of the Kalman filter top level. It accepts one burst at a time and grants in round-robin order. It registers the winning AR request and drives it onto the master port, then routes R beats back to the owner. Ownership ends after arlen+1 beats.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_W, 32, AXI address width
DATA_W, 512, AXI data width
TIMEOUT_CYC, 1024, R-channel stall limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_araddr  in  NUM_REQ*ADDR_W  per-requester AR address (requester i in slice i)
s_arlen  in  NUM_REQ*8  per-requester burst length minus 1
s_arsize  in  NUM_REQ*3  per-requester beat size
s_arburst  in  NUM_REQ*2  per-requester burst type
s_arvalid  in  NUM_REQ  per-requester AR valid
s_arready  out  NUM_REQ  per-requester AR ready (one-hot or zero)
s_rdata  out  DATA_W  R data, broadcast to all requesters
s_rvalid  out  NUM_REQ  R valid, asserted only toward the owner
s_rready  in  NUM_REQ  per-requester R ready
m_araddr / m_arlen / m_arsize / m_arburst  out  ADDR_W/8/3/2  master AR fields
m_arvalid  out  1  master AR valid
m_arready  in  1  master AR ready
m_rdata  in  DATA_W  master R data
m_rvalid  in  1  master R valid
m_rready  out  1  master R ready
busy  out  1  high outside IDLE
grant_id  out  2  current or last owner index
timeout_err  out  1  one-cycle pulse on R timeout (optional feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0.
  - last_grant=NUM_REQ-1, so requester 0 wins the first tie.
  - Reset mid-burst drops the burst; the slave is responsible for flushing.
- IDLE:
  - winner = first i with s_arvalid[i]=1, searching from last_grant+1 modulo NUM_REQ.
  - s_arready[winner]=1 combinationally in the same cycle; this is the accepting handshake.
  - On that edge: capture addr/len/size/burst, set grant_id=winner and last_grant=winner, clear the beat counter, go to ADDR.
  - With no s_arvalid, stay in IDLE; all s_arready=0.
- ADDR:
  - m_arvalid=1 from registers; fields stay stable until m_arready.
  - AR latency: accepted at cycle N, m_arvalid high at N+1.
  - On m_arvalid & m_arready, go to DATA.
  - All s_arready=0 in ADDR and DATA.
- DATA:
  - m_rready = s_rready[grant_id].
  - s_rvalid[grant_id] = m_rvalid; other s_rvalid bits are 0.
  - s_rdata = m_rdata, combinational, no added latency.
  - Each m_rvalid & m_rready handshake increments the 8-bit beat counter.
  - On the handshake where counter == latched arlen, go to IDLE. arlen=0 means a single beat; 255 means 256 beats, with no counter overflow.
- Back-to-back: the DATA→IDLE cycle is followed by an IDLE acceptance cycle. Minimum gap between bursts is 1 cycle.
- m_rvalid in IDLE/ADDR: m_rready=0; the beat is not consumed and not routed.
- s_arvalid may be held by a losing requester indefinitely. Round-robin guarantees a grant within NUM_REQ bursts.
- busy = (state != IDLE).
- grant_id is zero-extended when NUM_REQ ≤ 2.

Optional Feature:
KF_RD_ARB_TIMEOUT_EN
- Defined:
  - a stall counter runs in DATA; it clears on every R handshake and on state entry;
  - when it reaches TIMEOUT_CYC-1 with no handshake: timeout_err pulses 1 cycle and state returns to IDLE (owner released).
- Undefined: no counter logic; timeout_err tied 0; DATA waits forever.

Decomposition:
- Shared package kf_axi_pkg:
  - typedef arb_state_t {IDLE, ADDR, DATA};
  - AXI_BURST_INCR=2'b01 and AXI_SIZE_64B=3'b110 constants;
  - struct axi_ar_t {addr, len, size, burst}, used for the capture register.
- One natural sub-module, kf_rr_pick: combinational round-robin priority picker. Input is the request vector plus last_grant; output is a one-hot grant plus index.

Test Plan:
- Reset released, s_arvalid[0]=1 (addr 0x0030_0000, len 3), m_arready=1 → s_arready[0] pulse; next cycle m_arvalid=1 with m_araddr=0x0030_0000, m_arlen=3; 4 R beats routed to s_rvalid[0]; busy falls after beat 4.
- Both requesters valid continuously, 4 bursts of len 0 → grant order 0,1,0,1; each s_arready single-cycle, never both high.
- Requester 1 granted, m_arready held 0 for 5 cycles → m_arvalid and m_araddr stable for 6 cycles; no s_arready to requester 0 meanwhile.
- DATA, len 7, owner's s_rready toggles 1,0,1,0 → m_rready follows; exactly 8 handshakes counted; no beat visible on s_rvalid[1].
- rst_n asserted mid-DATA after beat 2 of 8 → all outputs 0 immediately (async); after release, requester 0 wins first.
- Macro defined, TIMEOUT_CYC=16, m_rvalid stuck 0 in DATA → timeout_err pulses at the 16th stalled cycle and state returns to IDLE. Macro undefined, same stimulus → busy stays 1 and timeout_err stays 0.
